// File: rtl/match_event_logger.sv
// Match event logger: stamps each 1010 detector hit with its stream
// position, queues the stamps in a small FIFO and keeps hit/overflow stats.
module match_event_logger #(
   parameter int POS_W = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     bit_valid,
   input  logic                     det_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [POS_W-1:0]         out_pos,
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         hit_cnt,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [POS_W-1:0] pos;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [POS_W-1:0] mem [DEPTH];

   logic push;
   logic pop;
   logic full;
   logic wr_en;
   logic drop;

   assign full      = (level == FULL);
   assign out_valid = (level != '0);
   assign push      = bit_valid & det_in;
   assign pop       = out_valid & out_ready;
   // A full FIFO still accepts a push when the head leaves on the same edge
   assign wr_en     = push & (~full | pop);
   assign drop      = push & full & ~pop;
   assign out_pos   = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         hit_cnt  <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         pos      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         hit_cnt  <= '0;
         overflow <= 1'b0;
      end else begin
         if (bit_valid)
            pos <= pos + POS_W'(1);
         if (wr_en)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (wr_en && !pop)
            level <= level + (AW+1)'(1);
         else if (pop && !wr_en)
            level <= level - (AW+1)'(1);
         if (push && hit_cnt != '1)
            hit_cnt <= hit_cnt + CNT_W'(1);
         if (drop)
            overflow <= 1'b1;
      end
   end

   // Storage needs no reset: out_pos is gated by level
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= pos;
   end

endmodule

// File: tb/tb_match_event_logger.sv
// Bench for match_event_logger: queue-based reference model, per-cycle
// compare, directed scenarios with literal expectations, random traffic.
module tb_match_event_logger;

   localparam int POS_W = 8;
   localparam int DEPTH = 4;
   localparam int CNT_W = 5;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             clr = 1'b0;
   logic             bit_valid = 1'b0;
   logic             det_in = 1'b0;
   logic             out_ready = 1'b0;
   logic             out_valid;
   logic [POS_W-1:0] out_pos;
   logic [LW-1:0]    level;
   logic [CNT_W-1:0] hit_cnt;
   logic             overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   match_event_logger #(
      .POS_W(POS_W),
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .bit_valid(bit_valid),
      .det_in(det_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_pos(out_pos),
      .level(level),
      .hit_cnt(hit_cnt),
      .overflow(overflow)
   );

   // reference model
   int m_pos = 0;
   int m_q[$];
   int m_hit = 0;
   bit m_ovf = 1'b0;

   always @(posedge clk or posedge rst) begin : model
      bit push;
      bit pop;
      if (rst) begin
         m_pos = 0;
         m_q.delete();
         m_hit = 0;
         m_ovf = 1'b0;
      end else if (clr) begin
         m_pos = 0;
         m_q.delete();
         m_hit = 0;
         m_ovf = 1'b0;
      end else begin
         push = bit_valid && det_in;
         pop  = (m_q.size() > 0) && out_ready;
         if (pop)
            void'(m_q.pop_front());
         if (push) begin
            if (m_hit < (1 << CNT_W) - 1)
               m_hit++;
            if (m_q.size() < DEPTH)
               m_q.push_back(m_pos);
            else
               m_ovf = 1'b1;
         end
         if (bit_valid)
            m_pos = (m_pos + 1) % (1 << POS_W);
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
                  $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cmp_valid", 32'(out_valid), 32'(m_q.size() > 0));
      chk("cmp_pos", 32'(out_pos), (m_q.size() > 0) ? m_q[0] : 0);
      chk("cmp_level", 32'(level), m_q.size());
      chk("cmp_hit", 32'(hit_cnt), m_hit);
      chk("cmp_ovf", 32'(overflow), 32'(m_ovf));
   end

   task automatic cyc(input bit bv, input bit det, input bit rdy);
      bit_valid = bv;
      det_in    = det;
      out_ready = rdy;
      @(negedge clk);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      clr = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_pos", 32'(out_pos), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_hit", 32'(hit_cnt), 0);
      chk("rst_ovf", 32'(overflow), 0);
      rst = 1'b0;

      // hits at bits 3 and 5, no consumer
      for (int i = 0; i < 10; i++)
         cyc(1'b1, (i == 3 || i == 5), 1'b0);
      chk("s1_level", 32'(level), 2);
      chk("s1_hit", 32'(hit_cnt), 2);
      chk("s1_pos", 32'(out_pos), 3);
      cyc(1'b0, 1'b0, 1'b1);
      chk("s1_pos2", 32'(out_pos), 5);
      cyc(1'b0, 1'b0, 1'b1);
      chk("s1_empty", 32'(out_valid), 0);

      // overflow: six pushes into four slots
      do_clr();
      for (int i = 0; i < 6; i++)
         cyc(1'b1, 1'b1, 1'b0);
      chk("s2_level", 32'(level), 4);
      chk("s2_hit", 32'(hit_cnt), 6);
      chk("s2_ovf", 32'(overflow), 1);
      for (int i = 0; i < 4; i++) begin
         chk("s2_drain", 32'(out_pos), i);
         cyc(1'b0, 1'b0, 1'b1);
      end
      chk("s2_empty", 32'(out_valid), 0);
      chk("s2_ovf_sticky", 32'(overflow), 1);

      // push and pop on the same edge while full
      do_clr();
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      chk("s3_level", 32'(level), 4);
      chk("s3_ovf", 32'(overflow), 0);
      for (int i = 1; i < 5; i++) begin
         chk("s3_drain", 32'(out_pos), i);
         cyc(1'b0, 1'b0, 1'b1);
      end

      // position wrap
      do_clr();
      for (int i = 0; i < 256; i++)
         cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("s4_pos", 32'(out_pos), 0);
      chk("s4_level", 32'(level), 1);

      // det_in without bit_valid is ignored
      do_clr();
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("s5_level", 32'(level), 0);
      chk("s5_hit", 32'(hit_cnt), 0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("s5_pos", 32'(out_pos), 3);

      // async reset mid-cycle, then clr on a push edge
      do_clr();
      for (int i = 0; i < 5; i++)
         cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      chk("s6_level", 32'(level), 3);
      chk("s6_ovf", 32'(overflow), 1);
      #2 rst = 1'b1;
      #1;
      chk("s6_rst_valid", 32'(out_valid), 0);
      chk("s6_rst_pos", 32'(out_pos), 0);
      chk("s6_rst_level", 32'(level), 0);
      chk("s6_rst_hit", 32'(hit_cnt), 0);
      chk("s6_rst_ovf", 32'(overflow), 0);
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b1, 1'b1, 1'b0);
      chk("s6_first", 32'(out_pos), 0);
      cyc(1'b1, 1'b1, 1'b0);
      clr = 1'b1;
      cyc(1'b1, 1'b1, 1'b0);
      clr = 1'b0;
      chk("s6_clr_level", 32'(level), 0);
      chk("s6_clr_hit", 32'(hit_cnt), 0);
      chk("s6_clr_valid", 32'(out_valid), 0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("s6_clr_pos", 32'(out_pos), 0);

      // random traffic, consumer pace varies per block
      do_clr();
      for (int b = 0; b < 20; b++) begin
         int rdy_pct;
         rdy_pct = $urandom_range(5, 95);
         for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 299) == 0)
               clr = 1'b1;
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                $urandom_range(0, 99) < rdy_pct);
            clr = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
